burst_mem_responder: RTL and testbench
======================================

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning the backing store holds 2^DEPTH_LOG2 64-bit words.
REQ-002 SHALL have parameter REFRESH_PERIOD, default 0, meaning the number of cycles between refresh stalls; 0 disables refresh.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 4, meaning the length of a refresh stall in cycles.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ddr_rd, input, 1 bit: read burst request.
REQ-007 SHALL have port ddr_wr, input, 1 bit: write beat valid.
REQ-008 SHALL have port ddr_addr, input, 32 bits: byte address; bits [2:0] are ignored.
REQ-009 SHALL have port ddr_mask, input, 8 bits: byte-enable for the write beat; bit i enables byte i.
REQ-010 SHALL have port ddr_din, input, 64 bits: write data.
REQ-011 SHALL have port ddr_burstLength, input, 8 bits: beats per burst; 0 is treated as 1.
REQ-012 SHALL have port ddr_dout, output, 64 bits: read data.
REQ-013 SHALL have port ddr_wait_n, output, 1 bit: high when a request or write beat is accepted this cycle.
REQ-014 SHALL have port ddr_valid, output, 1 bit: ddr_dout carries one read beat.

Function
REQ-015 SHALL implement the states IDLE, READ and WRITE.
REQ-016 SHALL drive ddr_wait_n combinationally:
- 1 in IDLE when no refresh stall is active, and in WRITE;
- 0 in READ, during a refresh stall, and while reset is low.
REQ-017 SHALL accept a read in IDLE when ddr_rd and ddr_wait_n are both 1, latching word address ddr_addr[DEPTH_LOG2+2:3] and the burst length, then go to READ.
REQ-018 SHALL give ddr_rd priority when ddr_rd and ddr_wr are both 1 in IDLE; the write is not accepted that cycle.
REQ-019 SHALL time reads as follows for a read accepted in cycle T with length N:
- issue one RAM read per cycle in cycles T+1 through T+N;
- assert ddr_valid with data for beat i in cycle T+2+i;
- return to IDLE so that ddr_wait_n is 1 again in cycle T+N+1.
REQ-020 SHALL hold ddr_dout at its last value when ddr_valid is 0.
REQ-021 SHALL write the first beat in IDLE when ddr_wr and ddr_wait_n are both 1: ddr_din goes to the word address under ddr_mask, and the address and length are latched.
REQ-022 SHALL stay in IDLE after that first write beat if the length is 0 or 1; otherwise it SHALL go to WRITE with the beat counter at 1.
REQ-023 SHALL, in WRITE, write each cycle with ddr_wr=1 to the latched address plus the counter, then increment the counter.
REQ-024 SHALL hold the counter in WRITE on cycles with ddr_wr=0, and SHALL ignore ddr_rd in WRITE.
REQ-025 SHALL return to IDLE on the beat where counter equals length-1.
REQ-026 SHALL wrap beat addresses modulo 2^DEPTH_LOG2.
REQ-027 SHALL apply byte masking only to writes; masked-off bytes keep their prior value.
REQ-028 SHALL count refresh cycles with a free-running counter that requests a stall every REFRESH_PERIOD cycles.
REQ-029 SHALL start a requested stall only in IDLE and only when no request is accepted that cycle; a request arriving during a burst is deferred until IDLE.

Reset
REQ-030 SHALL, while reset is low, force state=IDLE, ddr_valid=0, ddr_dout=0, all counters=0 and the refresh counter=0.
REQ-031 SHALL abandon any burst in progress on reset assertion with no further ddr_valid pulses; RAM contents are not cleared.

Structure
REQ-032 SHALL take the state enum and the widths DATA_W=64, ADDR_W=32, MASK_W=8 and BURST_W=8 from the shared package ddr_pkg.
REQ-033 SHALL place the backing store in one sub-module, burst_ram:
- single-port, synchronous read with 1-cycle latency;
- byte-enable write.
Read and write never coincide, by the state machine.

Verification
REQ-034 SHALL cover: a write at addr 0x100 with length 4 and data 0xA0..0xA3, beats back-to-back, then a read at 0x100 with length 4 -> ddr_valid for 4 consecutive cycles, starting 2 cycles after the read is accepted, carrying 0xA0..0xA3.
REQ-035 SHALL cover: write 0xFFFF_FFFF_FFFF_FFFF at 0x08 with mask 0xFF, then write 0 with mask 0x0F, then read length 1 -> 0xFFFF_FFFF_0000_0000.
REQ-036 SHALL cover: ddr_rd=1 and ddr_wr=1 together in IDLE with length 2 -> a read burst is accepted, no RAM write occurs, and ddr_wait_n=0 for 2 cycles.
REQ-037 SHALL cover: a write with length 3 where ddr_wr drops for 2 cycles after beat 1 -> the counter holds, and all 3 words are written to consecutive addresses.
REQ-038 SHALL cover: REFRESH_PERIOD=16, REFRESH_CYCLES=4, and a read held pending -> ddr_wait_n=0 for exactly 4 IDLE cycles, then the read is accepted.
REQ-039 SHALL cover: reset asserted in cycle T+3 of an 8-beat read -> ddr_valid=0 from the next edge, and IDLE with ddr_wait_n=1 after release.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared widths, state encoding and helpers for the burst memory responder.
package ddr_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned MASK_W  = 8;
    localparam int unsigned BURST_W = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2
    } ddr_state_e;

    // A zero burst length behaves as a single beat.
    function automatic logic [BURST_W-1:0] eff_burst_len(input logic [BURST_W-1:0] len);
        return (len == '0) ? BURST_W'(1) : len;
    endfunction

endpackage

// File: rtl/burst_ram.sv
// Single-port backing store: synchronous read (1-cycle latency), byte-enable write.
module burst_ram
    import ddr_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [MASK_W-1:0]     wr_mask,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] rd_data_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (wr_mask[b]) begin
                    mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Burst read/write responder in front of a single-port RAM, with optional
// periodic refresh stalls that are only taken while idle.
module burst_mem_responder
    import ddr_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2     = 12,
    parameter int unsigned REFRESH_PERIOD = 0,
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ddr_rd,
    input  logic               ddr_wr,
    input  logic [ADDR_W-1:0]  ddr_addr,
    input  logic [MASK_W-1:0]  ddr_mask,
    input  logic [DATA_W-1:0]  ddr_din,
    input  logic [BURST_W-1:0] ddr_burstLength,
    output logic [DATA_W-1:0]  ddr_dout,
    output logic               ddr_wait_n,
    output logic               ddr_valid
);

    localparam bit RefreshEn = (REFRESH_PERIOD != 0) && (REFRESH_CYCLES != 0);

    ddr_state_e state_q, state_d;
    logic [BURST_W-1:0]    cnt_q, cnt_d;
    logic [BURST_W-1:0]    len_q, len_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;
    logic                  valid_q;

    logic [31:0] rfsh_cnt_q, rfsh_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        rfsh_pend_q, rfsh_pend_d;
    logic        rfsh_tick, stall_start, stall;

    logic                  ram_rd, ram_wr;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DEPTH_LOG2-1:0] word_addr;
    logic [BURST_W-1:0]    req_len;
    logic                  unused_addr_bits;

    assign word_addr        = ddr_addr[DEPTH_LOG2+2:3];
    assign req_len          = eff_burst_len(ddr_burstLength);
    assign unused_addr_bits = ^{ddr_addr[ADDR_W-1:DEPTH_LOG2+3], ddr_addr[2:0]};

    // A pending refresh blocks acceptance in the same cycle it starts, so it can
    // never lose to a request that is held continuously.
    always_comb begin
        rfsh_tick   = 1'b0;
        stall_start = 1'b0;
        rfsh_cnt_d  = '0;
        rfsh_pend_d = 1'b0;
        stall_cnt_d = '0;
        if (RefreshEn) begin
            rfsh_tick   = (rfsh_cnt_q == 32'(REFRESH_PERIOD - 1));
            stall_start = (state_q == StIdle) && rfsh_pend_q && (stall_cnt_q == '0);
            rfsh_cnt_d  = rfsh_tick ? '0 : rfsh_cnt_q + 32'd1;
            rfsh_pend_d = (rfsh_pend_q && !stall_start) || rfsh_tick;
            if (stall_start) begin
                stall_cnt_d = 32'(REFRESH_CYCLES - 1);
            end else if (stall_cnt_q != '0) begin
                stall_cnt_d = stall_cnt_q - 32'd1;
            end
        end
    end

    assign stall      = stall_start || (stall_cnt_q != '0);
    assign ddr_wait_n = reset && (((state_q == StIdle) && !stall) || (state_q == StWrite));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        base_d   = base_q;
        ram_rd   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = base_q + DEPTH_LOG2'(cnt_q);
        unique case (state_q)
            StIdle: begin
                if (ddr_wait_n && ddr_rd) begin
                    base_d  = word_addr;
                    len_d   = req_len;
                    cnt_d   = '0;
                    state_d = StRead;
                end else if (ddr_wait_n && ddr_wr) begin
                    ram_wr   = 1'b1;
                    ram_addr = word_addr;
                    base_d   = word_addr;
                    len_d    = req_len;
                    if (req_len > BURST_W'(1)) begin
                        cnt_d   = BURST_W'(1);
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                ram_rd = 1'b1;
                if (cnt_q == len_q - BURST_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + BURST_W'(1);
                end
            end
            StWrite: begin
                if (ddr_wr) begin
                    ram_wr = 1'b1;
                    if (cnt_q == len_q - BURST_W'(1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + BURST_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            valid_q     <= 1'b0;
            rfsh_cnt_q  <= '0;
            rfsh_pend_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            valid_q     <= ram_rd;
            rfsh_cnt_q  <= rfsh_cnt_d;
            rfsh_pend_q <= rfsh_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ddr_valid = valid_q;

    burst_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .rd_en  (ram_rd),
        .wr_en  (ram_wr),
        .addr   (ram_addr),
        .wr_mask(ddr_mask),
        .wr_data(ddr_din),
        .rd_data(ddr_dout)
    );

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed and randomized checks of burst_mem_responder against an array model
// of the memory plus cycle-level expectations of handshake timing.
module tb_burst_mem_responder;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic        clock;
    logic        reset;
    logic        ddr_rd, ddr_wr;
    logic [31:0] ddr_addr;
    logic [7:0]  ddr_mask;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_burstLength;
    logic [63:0] ddr_dout;
    logic        ddr_wait_n, ddr_valid;

    logic        rf_rd;
    logic [7:0]  rf_len;
    logic [63:0] rf_dout_unused;
    logic        rf_wait_n, rf_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model_mem [DEPTH];
    logic [63:0] wdata [256];
    logic [7:0]  wmask [256];

    burst_mem_responder #(
        .DEPTH_LOG2(AW), .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset), .ddr_rd(ddr_rd), .ddr_wr(ddr_wr),
        .ddr_addr(ddr_addr), .ddr_mask(ddr_mask), .ddr_din(ddr_din),
        .ddr_burstLength(ddr_burstLength), .ddr_dout(ddr_dout),
        .ddr_wait_n(ddr_wait_n), .ddr_valid(ddr_valid)
    );

    burst_mem_responder #(
        .DEPTH_LOG2(AW), .REFRESH_PERIOD(16), .REFRESH_CYCLES(4)
    ) dut_rf (
        .clock(clock), .reset(reset), .ddr_rd(rf_rd), .ddr_wr(1'b0),
        .ddr_addr(32'h0000_0040), .ddr_mask(8'hFF), .ddr_din(64'h0),
        .ddr_burstLength(rf_len), .ddr_dout(rf_dout_unused),
        .ddr_wait_n(rf_wait_n), .ddr_valid(rf_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] byte_addr(input int word);
        return ($urandom << (AW + 3)) | (32'(word) << 3) | 32'($urandom_range(0, 7));
    endfunction

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 20 && !ddr_wait_n; k++) step();
        check(tag, ddr_wait_n, 1'b1);
    endtask

    // Writes n beats from wdata/wmask; optional idle gap of gap_len after beat gap_at.
    task automatic do_write(input int word, input int blen, input int gap_at, input int gap_len);
        int n;
        n = (blen == 0) ? 1 : blen;
        wait_idle("wr_idle");
        for (int i = 0; i < n; i++) begin
            ddr_rd          = 1'b0;
            ddr_wr          = 1'b1;
            ddr_addr        = byte_addr((word + 7 * i) % DEPTH);
            if (i == 0) ddr_addr = byte_addr(word);
            ddr_burstLength = 8'(blen);
            ddr_din         = wdata[i];
            ddr_mask        = wmask[i];
            check("wr_wait_n", ddr_wait_n, 1'b1);
            model_mem[(word + i) % DEPTH] = merge(model_mem[(word + i) % DEPTH], wdata[i], wmask[i]);
            step();
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    ddr_wr   = 1'b0;
                    ddr_din  = {$urandom, $urandom};
                    ddr_addr = $urandom;
                    check("wr_gap_wait_n", ddr_wait_n, 1'b1);
                    step();
                end
            end
        end
        ddr_wr = 1'b0;
    endtask

    // Issues a read burst (optionally with ddr_wr also high) and checks every beat.
    task automatic do_read(input int word, input int blen, input bit with_wr);
        int n;
        logic [63:0] last;
        n = (blen == 0) ? 1 : blen;
        wait_idle("rd_idle");
        ddr_rd          = 1'b1;
        ddr_wr          = with_wr;
        ddr_din         = {$urandom, $urandom};
        ddr_mask        = 8'hFF;
        ddr_addr        = byte_addr(word);
        ddr_burstLength = 8'(blen);
        step();
        ddr_rd = 1'b0;
        ddr_wr = 1'b0;
        check("rd_first_valid", ddr_valid, 1'b0);
        check("rd_first_wait_n", ddr_wait_n, 1'b0);
        last = '0;
        for (int i = 0; i < n; i++) begin
            step();
            last = model_mem[(word + i) % DEPTH];
            check("rd_valid", ddr_valid, 1'b1);
            check("rd_data", ddr_dout, last);
            check("rd_wait_n", ddr_wait_n, (i == n - 1) ? 1'b1 : 1'b0);
        end
        step();
        check("rd_end_valid", ddr_valid, 1'b0);
        check("rd_dout_hold", ddr_dout, last);
    endtask

    initial begin
        int word, blen, gap_at, s;
        ddr_rd = 0; ddr_wr = 0; ddr_addr = 0; ddr_mask = 0; ddr_din = 0; ddr_burstLength = 0;
        rf_rd = 0; rf_len = 8'd20;
        reset = 1'b0;

        // Reset state
        step();
        step();
        check("rst_wait_n", ddr_wait_n, 1'b0);
        check("rst_valid", ddr_valid, 1'b0);
        check("rst_dout", ddr_dout, 64'h0);
        reset = 1'b1;
        #1;
        check("post_rst_wait_n", ddr_wait_n, 1'b1);
        check("post_rst_valid", ddr_valid, 1'b0);

        // Fill the whole memory so every later read has a known model value
        for (int k = 0; k < DEPTH / 128; k++) begin
            for (int i = 0; i < 128; i++) begin
                wdata[i] = {$urandom, $urandom};
                wmask[i] = 8'hFF;
            end
            do_write(k * 128, 128, -1, 0);
        end

        // Back-to-back 4-beat write then 4-beat read at 0x100
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 64'hA0 + 64'(i);
            wmask[i] = 8'hFF;
        end
        do_write(32'h100 >> 3, 4, -1, 0);
        do_read(32'h100 >> 3, 4, 1'b0);
        check("burst4_last", ddr_dout, 64'hA3);

        // Byte-mask merge at 0x08
        wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; wmask[0] = 8'hFF;
        do_write(1, 1, -1, 0);
        wdata[0] = 64'h0; wmask[0] = 8'h0F;
        do_write(1, 1, -1, 0);
        do_read(1, 1, 1'b0);
        check("mask_merge", ddr_dout, 64'hFFFF_FFFF_0000_0000);

        // Read and write together: read wins, no write lands
        do_read(32'h200 >> 3, 2, 1'b1);
        do_read(32'h200 >> 3, 2, 1'b0);

        // Write stalls two cycles after beat 1; counter must hold
        for (int i = 0; i < 3; i++) begin
            wdata[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
            wmask[i] = 8'hFF;
        end
        do_write(50, 3, 1, 2);
        do_read(50, 3, 1'b0);

        // Length 0 behaves as 1 for both writes and reads
        wdata[0] = 64'h1234_5678_9ABC_DEF0; wmask[0] = 8'hFF;
        do_write(77, 0, -1, 0);
        do_read(77, 0, 1'b0);

        // Address wrap at the top of the array
        for (int i = 0; i < 3; i++) begin
            wdata[i] = 64'hBEEF_0000 + 64'(i);
            wmask[i] = 8'hFF;
        end
        do_write(DEPTH - 1, 3, -1, 0);
        do_read(DEPTH - 2, 4, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            word = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 0) begin
                blen = $urandom_range(0, 8);
                for (int i = 0; i < 8; i++) begin
                    wdata[i] = {$urandom, $urandom};
                    wmask[i] = 8'($urandom);
                end
                gap_at = (blen > 1) ? $urandom_range(0, blen - 2) : -1;
                do_write(word, blen, gap_at, $urandom_range(0, 2));
            end else begin
                do_read(word, $urandom_range(0, 12), 1'b0);
            end
        end

        // Reset in cycle T+3 of an 8-beat read
        word = 300;
        wait_idle("rst_rd_idle");
        ddr_rd = 1'b1; ddr_addr = byte_addr(word); ddr_burstLength = 8'd8;
        step();
        ddr_rd = 1'b0;
        step();
        step();
        check("rst_rd_beat1", ddr_dout, model_mem[word + 1]);
        reset = 1'b0;
        #1;
        check("rst_mid_valid", ddr_valid, 1'b0);
        check("rst_mid_dout", ddr_dout, 64'h0);
        check("rst_mid_wait_n", ddr_wait_n, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_hold_valid", ddr_valid, 1'b0);
        end
        reset = 1'b1;
        #1;
        check("rst_rel_wait_n", ddr_wait_n, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rst_rel_valid", ddr_valid, 1'b0);
            check("rst_rel_idle", ddr_wait_n, 1'b1);
        end
        do_read(word, 8, 1'b0);

        // Refresh: 4 low cycles every 16 while idle
        for (int k = 0; k < 40 && !rf_wait_n; k++) step();
        for (int k = 0; k < 40 && rf_wait_n; k++) step();
        check("rf_found_stall", rf_wait_n, 1'b0);
        for (int k = 1; k < 4; k++) begin
            step();
            check("rf_stall_low", rf_wait_n, 1'b0);
        end
        for (int k = 4; k < 16; k++) begin
            step();
            check("rf_idle_high", rf_wait_n, 1'b1);
        end
        step();
        check("rf_period", rf_wait_n, 1'b0);

        // Read held through a stall, then a long burst covering the next tick
        rf_rd = 1'b1;
        for (s = 0; s <= 30; s++) begin
            if (s == 5) rf_rd = 1'b0;
            check("rf_seq_wait_n", rf_wait_n, (s == 4 || s >= 29) ? 1'b1 : 1'b0);
            check("rf_seq_valid", rf_valid, (s >= 6 && s <= 25) ? 1'b1 : 1'b0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
